// File: rtl/vault_pkg.sv
// Shared types and constants for the vault phase controller: FSM states,
// cur_phase codes, checker bit positions and the registered output bundle.
package vault_pkg;

    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_PHASE_TIMEOUT  = 32;
    localparam int DEF_LOCKOUT_CYCLES = 64;

    localparam int NUM_PHASES = 4;

    // Checker bit positions within phase_done / phase_fail / phase_en
    localparam int PH_CODE   = 0;
    localparam int PH_SWITCH = 1;
    localparam int PH_MAZE   = 2;
    localparam int PH_PLATE  = 3;

    localparam logic [2:0] CP_IDLE  = 3'd0;
    localparam logic [2:0] CP_TLOCK = 3'd5;
    localparam logic [2:0] CP_DONE  = 3'd6;
    localparam logic [2:0] CP_LOCK  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_TLOCK,
        ST_DONE,
        ST_LOCKOUT
    } state_t;

    typedef struct packed {
        logic [NUM_PHASES-1:0] phase_en;
        logic                  phase_clr;
        logic                  tl_start;
        logic [2:0]            cur_phase;
        logic                  all_done;
        logic                  lockout;
    } ctrl_out_t;

    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [1:0] idx);
        return NUM_PHASES'(1) << idx;
    endfunction

    function automatic logic [2:0] phase_code(input logic [1:0] idx);
        return 3'({1'b0, idx}) + 3'd1;
    endfunction

endpackage

// File: rtl/vault_timer.sv
// Up-counter with synchronous clear and run-time limit; expire is high while
// the count sits on the limit. Shared by phase timeout and lockout timing.
module vault_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == limit);

endmodule

// File: rtl/vault_phase_ctrl.sv
// Vault run sequencer: walks four checker phases, then the time-lock, with a
// shared timer bounding each phase and the post-failure lockout.
module vault_phase_ctrl
    import vault_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int PHASE_TIMEOUT  = DEF_PHASE_TIMEOUT,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] phase_done,
    input  logic [3:0] phase_fail,
    input  logic       tl_done,
    output logic [3:0] phase_en,
    output logic       phase_clr,
    output logic       tl_start,
    output logic [2:0] cur_phase,
    output logic [1:0] attempts_left,
    output logic       all_done,
    output logic       lockout
);

    localparam int TMR_MAX = (PHASE_TIMEOUT > LOCKOUT_CYCLES) ? PHASE_TIMEOUT : LOCKOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    state_t    state, nxt_state;
    logic [1:0] idx, nxt_idx;
    logic [1:0] att, nxt_att;
    ctrl_out_t out_q, nxt_out;

    logic          tmr_load, tmr_en, tmr_expire;
    logic [TW-1:0] tmr_limit;
    logic          cur_done, cur_fail;

    vault_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .en     (tmr_en),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );

    // Only the active checker's status bits matter; the rest are ignored.
    assign cur_done = phase_done[idx];
    assign cur_fail = phase_fail[idx];

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_att   = att;
        tmr_en    = 1'b0;
        tmr_limit = TW'(PHASE_TIMEOUT - 1);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_state = ST_CLR;
                    nxt_idx   = 2'd0;
                end
            end
            ST_CLR: nxt_state = ST_RUN;
            ST_RUN: begin
                tmr_en = 1'b1;
                // Fail dominates a simultaneous done; done beats a timeout.
                if (cur_fail || (!cur_done && tmr_expire)) begin
                    if (att <= 2'd1) begin
                        nxt_att   = 2'd0;
                        nxt_state = ST_LOCKOUT;
                    end else begin
                        nxt_att   = att - 2'd1;
                        nxt_idx   = 2'd0;
                        nxt_state = ST_CLR;
                    end
                end else if (cur_done) begin
                    if (idx == 2'd3) begin
                        nxt_state = ST_TLOCK;
                    end else begin
                        nxt_idx   = idx + 2'd1;
                        nxt_state = ST_CLR;
                    end
                end
            end
            ST_TLOCK: begin
                if (tl_done)
                    nxt_state = ST_DONE;
            end
            ST_DONE: nxt_state = ST_DONE;
            ST_LOCKOUT: begin
                tmr_en    = 1'b1;
                tmr_limit = TW'(LOCKOUT_CYCLES - 1);
                if (tmr_expire) begin
                    nxt_att   = 2'(MAX_ATTEMPTS);
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Every state change restarts the timer, so each phase and the lockout
    // begin counting from zero.
    assign tmr_load = (nxt_state != state);

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        nxt_out = '0;
        case (nxt_state)
            ST_CLR: begin
                nxt_out.phase_clr = 1'b1;
                nxt_out.cur_phase = phase_code(nxt_idx);
            end
            ST_RUN: begin
                nxt_out.phase_en  = phase_onehot(nxt_idx);
                nxt_out.cur_phase = phase_code(nxt_idx);
            end
            ST_TLOCK: begin
                nxt_out.tl_start  = (state != ST_TLOCK);
                nxt_out.cur_phase = CP_TLOCK;
            end
            ST_DONE: begin
                nxt_out.all_done  = 1'b1;
                nxt_out.cur_phase = CP_DONE;
            end
            ST_LOCKOUT: begin
                nxt_out.lockout   = 1'b1;
                nxt_out.cur_phase = CP_LOCK;
            end
            default: nxt_out.cur_phase = CP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            att   <= 2'(MAX_ATTEMPTS);
            out_q <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            att   <= nxt_att;
            out_q <= nxt_out;
        end
    end

    assign phase_en      = out_q.phase_en;
    assign phase_clr     = out_q.phase_clr;
    assign tl_start      = out_q.tl_start;
    assign cur_phase     = out_q.cur_phase;
    assign all_done      = out_q.all_done;
    assign lockout       = out_q.lockout;
    assign attempts_left = att;

endmodule

// File: doc/vault_phase_ctrl.md
VAULT_PHASE_CTRL -- requirements
Module: vault_phase_ctrl

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 3: failed runs allowed before lockout.
REQ-002 SHALL have parameter PHASE_TIMEOUT, default 32: cycles allowed per phase in RUN.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 64: lockout duration in cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 resets on the clk edge).
REQ-006 SHALL have port start  input  1  level; begins a vault run from IDLE.
REQ-007 SHALL have port phase_done  input  4  per-checker success (bit0 code, bit1 switch, bit2 maze, bit3 plate).
REQ-008 SHALL have port phase_fail  input  4  per-checker failure, same bit order.
REQ-009 SHALL have port tl_done  input  1  time-lock sequence finished.
REQ-010 SHALL have port phase_en  output  4  one-hot enable of the active checker.
REQ-011 SHALL have port phase_clr  output  1  one-cycle clear pulse to the checker about to be enabled.
REQ-012 SHALL have port tl_start  output  1  one-cycle time-lock start pulse.
REQ-013 SHALL have port cur_phase  output  3  0 idle, 1-4 phase, 5 time-lock, 6 done, 7 lockout.
REQ-014 SHALL have port attempts_left  output  2  remaining attempts.
REQ-015 SHALL have port all_done  output  1  vault open, sticky.
REQ-016 SHALL have port lockout  output  1  high throughout LOCKOUT.

Function
REQ-017 SHALL implement states IDLE, CLR, RUN, TLOCK, DONE, LOCKOUT plus a 2-bit phase index idx.
REQ-018 IDLE: start=1 -> idx=0, CLR next cycle; otherwise stay.
REQ-019 CLR: phase_clr=1 and phase_en=0 for exactly one cycle; timeout counter zeroed; -> RUN.
REQ-020 RUN: phase_en=1<<idx; timeout counter increments every cycle.
REQ-021 RUN: only bits phase_done[idx]/phase_fail[idx] are sampled; other bits ignored.
REQ-022 RUN: phase_fail[idx] and phase_done[idx] high together SHALL be treated as fail.
REQ-023 RUN: done with idx<3 -> idx+1, CLR; done with idx=3 -> TLOCK.
REQ-024 RUN: fail, or counter reaching PHASE_TIMEOUT-1 without done, SHALL decrement attempts_left.
REQ-025 After a fail: attempts_left becoming 0 -> LOCKOUT; else idx=0, CLR (restart from phase 1).
REQ-026 TLOCK: tl_start=1 on first TLOCK cycle only; tl_done=1 -> DONE; no timeout in TLOCK.
REQ-027 DONE: all_done=1, phase_en=0; held until reset; start ignored.
REQ-028 LOCKOUT: lockout=1 for exactly LOCKOUT_CYCLES cycles, start ignored; then attempts_left=MAX_ATTEMPTS, -> IDLE.
REQ-029 cur_phase SHALL be registered and equal idx+1 in CLR/RUN, per REQ-013 elsewhere.
REQ-030 All outputs SHALL be registered; decisions take effect one cycle after the sampled input.

Reset
REQ-031 reset=0 SHALL, from any state, force IDLE, idx=0, counters 0, attempts_left=MAX_ATTEMPTS.
REQ-032 Under reset: phase_en=0, phase_clr=0, tl_start=0, cur_phase=0, all_done=0, lockout=0.
REQ-033 Reset mid-phase or mid-lockout SHALL discard progress; no pulse emitted on the release cycle.

Structure
REQ-034 Package vault_pkg SHALL hold the state enum, cur_phase codes, phase bit positions and parameter defaults.
REQ-035 Sub-module vault_timer (load/enable/expire counter) SHALL serve both phase timeout and lockout.

Verification
REQ-036 Happy path: start; done bits 0,1,2,3 pulsed one per phase; tl_done after 10 cycles -> four phase_clr pulses, phase_en 0001,0010,0100,1000, one tl_start, all_done=1, cur_phase=6.
REQ-037 Fail restart: pass phase 1, phase_fail[1]=1 -> attempts_left 3->2, phase_clr, phase_en=0001, cur_phase=1.
REQ-038 Timeout: start, no responses -> attempts_left decrements after 32 RUN cycles; after third timeout lockout=1 for 64 cycles, then IDLE with attempts_left=3.
REQ-039 Simultaneous/stray: phase_done=0011 and phase_fail=0001 in phase 1 -> fail taken; phase_done[2]=1 during phase 1 -> ignored.
REQ-040 Reset mid-run: reset=0 in phase 3 (maze) -> next cycle all outputs 0, attempts_left=3; start then re-enters phase 1.
